// File: rtl/gcd_req_arbiter.sv
// Round-robin front end that shares a single gcd unit among NUM_REQ requesters.
// Zero operands are answered directly; a watchdog bounds every gcd computation.
module gcd_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_timeout,
    output logic                       gcd_start,
    output logic [WIDTH-1:0]           gcd_a,
    output logic [WIDTH-1:0]           gcd_b,
    input  logic                       gcd_done,
    input  logic [WIDTH-1:0]           gcd_result,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT_CYCLES - 1);
    localparam logic [GCW-1:0] GCNT_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [GCW-1:0]   gcnt_q, gcnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] slot_a [NUM_REQ];
    logic [WIDTH-1:0] slot_b [NUM_REQ];
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_a[i] = req_a[i*WIDTH +: WIDTH];
            slot_b[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[cur_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_id_d  = cur_id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wcnt_d    = wcnt_q;
        gcnt_d    = gcnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        gcd_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d    = slot_a[grant_idx];
                    op_b_d    = slot_b[grant_idx];
                    cur_id_d  = grant_idx;
                    rr_ptr_d  = grant_idx;
                    timeout_d = 1'b0;
                    if (slot_a[grant_idx] == '0 || slot_b[grant_idx] == '0) begin
                        result_d = slot_a[grant_idx] | slot_b[grant_idx];
                        state_d  = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                gcd_start = 1'b1;
                wcnt_d    = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A done arriving on the final watchdog cycle still counts as success.
                if (gcd_done) begin
                    result_d  = gcd_result;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (wcnt_q == WCNT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            RESP: begin
                op_a_d  = '0;
                op_b_d  = '0;
                gcnt_d  = '0;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gcnt_q == GCNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IDW'(NUM_REQ - 1);
            cur_id_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wcnt_q    <= '0;
            gcnt_q    <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_id_q  <= cur_id_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wcnt_q    <= wcnt_d;
            gcnt_q    <= gcnt_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign rsp_result  = result_q;
    assign rsp_timeout = timeout_q && (state_q == RESP);
    assign gcd_a       = op_a_q;
    assign gcd_b       = op_b_q;
    assign busy        = (state_q != IDLE);
    assign cur_id      = cur_id_q;

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter: the bench plays the gcd unit by hand and
// checks every response against hand-computed values.
module tb_gcd_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_timeout;
    logic                     gcd_start;
    logic [WIDTH-1:0]         gcd_a;
    logic [WIDTH-1:0]         gcd_b;
    logic                     gcd_done;
    logic [WIDTH-1:0]         gcd_result;
    logic                     busy;
    logic [IDW-1:0]           cur_id;

    int n_cmp  = 0;
    int n_fail = 0;

    gcd_req_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(16), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_done(gcd_done), .gcd_result(gcd_result), .busy(busy), .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // One full gcd job; the bench raises done in the dly-th WAIT cycle.
    task automatic run_job(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int dly);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        wait_idle();
        set_req(id, a, b);
        req_valid = oh;
        #1 chk("job_ready", {28'd0, req_ready}, {28'd0, oh});
        tick();
        req_valid = '0;
        chk("job_start", {31'd0, gcd_start}, 32'd1);
        chk("job_gcd_a", gcd_a, a);
        chk("job_gcd_b", gcd_b, b);
        chk("job_cur_id", {30'd0, cur_id}, id);
        chk("job_ready_off", {28'd0, req_ready}, 32'd0);
        tick();
        chk("job_start_low", {31'd0, gcd_start}, 32'd0);
        chk("job_a_held", gcd_a, a);
        repeat (dly - 1) tick();
        chk("job_no_early_rsp", {28'd0, rsp_valid}, 32'd0);
        gcd_done   = 1'b1;
        gcd_result = res;
        tick();
        gcd_done = 1'b0;
        chk("job_rsp_valid", {28'd0, rsp_valid}, {28'd0, oh});
        chk("job_rsp_result", rsp_result, res);
        chk("job_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("job_rsp_start", {31'd0, gcd_start}, 32'd0);
    endtask

    task automatic bypass_case(input int id, input logic [31:0] a, input logic [31:0] b);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        wait_idle();
        set_req(id, a, b);
        req_valid = oh;
        #1 chk("byp_ready", {28'd0, req_ready}, {28'd0, oh});
        tick();
        req_valid = '0;
        chk("byp_rsp_valid", {28'd0, rsp_valid}, {28'd0, oh});
        chk("byp_result", rsp_result, a | b);
        chk("byp_no_start", {31'd0, gcd_start}, 32'd0);
        chk("byp_timeout", {31'd0, rsp_timeout}, 32'd0);
    endtask

    // Continuous requests with zero operand A, so each grant is answered next cycle.
    task automatic rr_grant(input int exp_id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[exp_id] = 1'b1;
        wait_idle();
        #1 chk("rr_ready", {28'd0, req_ready}, {28'd0, oh});
        tick();
        chk("rr_cur_id", {30'd0, cur_id}, exp_id);
        chk("rr_rsp_valid", {28'd0, rsp_valid}, {28'd0, oh});
        chk("rr_result", rsp_result, exp_id + 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_gcd_start", {31'd0, gcd_start}, 32'd0);
        chk("rst_gcd_a", gcd_a, 32'd0);
        chk("rst_gcd_b", gcd_b, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cur_id", {30'd0, cur_id}, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        gcd_done   = 1'b0;
        gcd_result = '0;
        tick();
        tick();
        chk_reset_outputs();
        reset_n = 1'b1;

        // Single requester, real gcd job: gcd(48,18)=6 after 5 WAIT cycles.
        run_job(2, 32'd48, 32'd18, 32'd6, 5);
        tick();
        chk("gap_ops_zero", gcd_a | gcd_b, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        chk("gap_no_rsp", {28'd0, rsp_valid}, 32'd0);

        // Round robin from a fresh reset.
        wait_idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'd0, i + 1);
        req_valid = 4'b1111;
        rr_grant(0);
        rr_grant(1);
        rr_grant(2);
        rr_grant(3);
        req_valid = 4'b1001;
        rr_grant(0);
        rr_grant(3);
        rr_grant(0);
        req_valid = '0;

        // Zero-operand bypass.
        bypass_case(1, 32'd0, 32'd35);
        bypass_case(1, 32'd0, 32'd0);
        bypass_case(1, 32'd12, 32'd0);

        // Watchdog: no done ever arrives.
        wait_idle();
        set_req(3, 32'd7, 32'd5);
        req_valid = 4'b1000;
        #1 chk("to_ready", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid = '0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_no_rsp", {28'd0, rsp_valid}, 32'd0);
            chk("to_wait_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("to_rsp_valid", {28'd0, rsp_valid}, 32'h8);
        chk("to_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
        chk("to_rsp_result", rsp_result, 32'd0);
        tick();
        tick();
        tick();
        gcd_done   = 1'b1;
        gcd_result = 32'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_done_no_rsp", {28'd0, rsp_valid}, 32'd0);
            chk("late_done_idle", {31'd0, busy}, 32'd0);
        end
        gcd_done = 1'b0;

        // Reset pulse while requester 1 waits on the gcd unit.
        wait_idle();
        set_req(1, 32'd48, 32'd18);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("mid_in_wait", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_outputs();
        gcd_done   = 1'b1;
        gcd_result = 32'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid_no_rsp", {28'd0, rsp_valid}, 32'd0);
        end
        gcd_done = 1'b0;
        set_req(0, 32'd9, 32'd0);
        set_req(1, 32'd0, 32'd4);
        req_valid = 4'b0011;
        #1 chk("post_rst_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0010;
        chk("post_rst_cur_id", {30'd0, cur_id}, 32'd0);
        chk("post_rst_rsp", {28'd0, rsp_valid}, 32'h1);
        chk("post_rst_result", rsp_result, 32'd9);
        wait_idle();
        #1 chk("post_rst_ready1", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        chk("post_rst_rsp1", {28'd0, rsp_valid}, 32'h2);
        chk("post_rst_result1", rsp_result, 32'd4);

        // Stray done while idle and during the gap.
        wait_idle();
        gcd_done   = 1'b1;
        gcd_result = 32'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_done_busy", {31'd0, busy}, 32'd0);
            chk("idle_done_rsp", {28'd0, rsp_valid}, 32'd0);
        end
        gcd_done = 1'b0;
        run_job(2, 32'd21, 32'd14, 32'd7, 3);
        gcd_done   = 1'b1;
        gcd_result = 32'd99;
        tick();
        chk("gap_done_rsp1", {28'd0, rsp_valid}, 32'd0);
        chk("gap_done_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("gap_done_rsp2", {28'd0, rsp_valid}, 32'd0);
        tick();
        chk("gap_done_rsp3", {28'd0, rsp_valid}, 32'd0);
        chk("gap_done_idle", {31'd0, busy}, 32'd0);
        gcd_done = 1'b0;
        run_job(1, 32'd100, 32'd75, 32'd25, 2);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_req_arbiter.md
Name: gcd_req_arbiter

Overview:
- Shares one gcd unit among NUM_REQ independent requesters.
- Each requester presents an operand pair through a valid/ready handshake.
- The block selects one requester round-robin, launches the gcd (start pulse, held operands), waits for done, and returns the result to that requester only.
- Zero operands bypass the gcd; a watchdog bounds each computation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- TIMEOUT_CYCLES, 1024, maximum number of WAIT cycles before the job is aborted.
- GAP_CYCLES, 2, idle cycles between the end of one job and the next arbitration (0 allowed).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-valid.
- req_a  in  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- req_ready  out  NUM_REQ  one-hot accept.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_result  out  WIDTH  gcd value, valid while any rsp_valid bit is high.
- rsp_timeout  out  1  set with rsp_valid when the job timed out.
- gcd_start  out  1  start pulse to the gcd unit.
- gcd_a  out  WIDTH  operand A to the gcd unit.
- gcd_b  out  WIDTH  operand B to the gcd unit.
- gcd_done  in  1  gcd completion.
- gcd_result  in  WIDTH  gcd result, sampled while gcd_done is high.
- busy  out  1  high in every state except IDLE.
- cur_id  out  $clog2(NUM_REQ)  index of the requester currently being served.

Behaviour:
- Reset (reset_n low at an edge): state=IDLE; rr_ptr=NUM_REQ-1; counters cleared.
- Outputs after reset: req_ready, rsp_valid, rsp_result, rsp_timeout, gcd_start, gcd_a, gcd_b, busy and cur_id all 0.
- Reset mid-operation aborts the job silently. No rsp_valid is issued for it; any later gcd_done or gcd_result is ignored.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - Winner g = first i with req_valid[i], searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in IDLE only; every other req_ready bit is 0.
  - Transfer occurs at the edge where req_valid[g] and req_ready[g] are both high. At that edge: capture a=req_a[g], b=req_b[g]; cur_id<=g; rr_ptr<=g.
  - Next state: RESP if a==0 or b==0 (bypass, result=a|b); otherwise ISSUE.
  - With no req_valid, remain in IDLE.
  - Requesters must hold req_valid and their operands until ready; the block does not check this.
- ISSUE: gcd_start=1 for exactly this one cycle; gcd_a/gcd_b driven from the captured operands. Next state is WAIT.
- WAIT:
  - gcd_start=0; gcd_a/gcd_b held constant.
  - wcnt increments from 0 each cycle.
  - gcd_done=1: register gcd_result into rsp_result and go to RESP with timeout=0.
  - wcnt==TIMEOUT_CYCLES-1 and gcd_done=0: rsp_result<=0, timeout=1, go to RESP.
  - If done and the final count coincide, done wins.
- RESP: rsp_valid[cur_id]=1 for one cycle, with rsp_timeout driven. There is no backpressure. Next state is GAP, or IDLE when GAP_CYCLES==0.
- GAP: stay GAP_CYCLES cycles, then go to IDLE. gcd_a/gcd_b are zeroed on GAP entry.
- gcd_done outside WAIT is ignored, including a late done after a timeout.
- Latency:
  - Handshake edge E; gcd_start high in cycle E+1; WAIT begins E+2.
  - done first seen in cycle k gives rsp_valid in cycle k+1.
  - Bypass: rsp_valid in cycle E+1.
  - Next possible accept: GAP_CYCLES+1 cycles after rsp_valid.
- Width: a|b bypass is WIDTH bits. wcnt width is $clog2(TIMEOUT_CYCLES)+1, so there is no wrap before timeout.

Test Plan:
- Requester 2 only, a=48, b=18; model asserts done 5 cycles after start with result 6 → single gcd_start pulse with gcd_a=48, gcd_b=18; rsp_valid=4'b0100 one cycle after done; rsp_result=6; rsp_timeout=0; cur_id=2.
- All 4 requesters valid continuously after reset → grants in order 0,1,2,3,0. After the grant to 3, only requesters 0 and 3 keep valid → grants alternate 0,3,0.
- Bypass cases:
  - a=0, b=35 → no gcd_start; rsp_result=35 one cycle after the handshake.
  - a=0, b=0 → rsp_result=0.
  - a=12, b=0 → rsp_result=12.
- TIMEOUT_CYCLES=16, model never asserts done → exactly 16 WAIT cycles, then rsp_valid with rsp_timeout=1 and rsp_result=0. A gcd_done injected 3 cycles later produces no response.
- Reset pulse of one cycle in WAIT (requester 1 active) → next cycle all outputs at reset values and no rsp_valid[1]. With requesters 1 and 0 then valid, requester 0 is granted first.
- gcd_done=1, gcd_result=99 forced while in IDLE or GAP → no rsp_valid, no state change; the following job's result is unaffected.
